// File: rtl/regfile_pkg.sv
// Shared defaults and the bulk-clear state type for the register file with scoreboard.
package regfile_pkg;

    localparam int DATA_W_DEF   = 8;
    localparam int NUM_REGS_DEF = 16;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CLEAR = 2'd1,
        DONE  = 2'd2
    } clr_state_e;

endpackage

// File: rtl/rf_clear_seq.sv
// Bulk-clear sequencer: walks every register index once, then pulses done.
//   state | meaning
//   IDLE  | waiting for clr_start, register file open to external writes
//   CLEAR | zeroing register clr_idx, one index per cycle
//   DONE  | one-cycle completion pulse, scoreboard wiped
module rf_clear_seq
    import regfile_pkg::*;
#(
    parameter int NUM_REGS = NUM_REGS_DEF,
    parameter int ADDR_W   = $clog2(NUM_REGS)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clr_start,
    output logic              clr_we,
    output logic [ADDR_W-1:0] clr_idx,
    output logic              clr_active,
    output logic              clr_done
);

    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NUM_REGS - 1);

    clr_state_e        state, state_nxt;
    logic [ADDR_W-1:0] idx, idx_nxt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            idx   <= '0;
        end else begin
            state <= state_nxt;
            idx   <= idx_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        idx_nxt    = idx;
        clr_we     = 1'b0;
        clr_active = 1'b0;
        clr_done   = 1'b0;
        case (state)
            IDLE: begin
                if (clr_start) begin
                    state_nxt = CLEAR;
                    idx_nxt   = '0;
                end
            end
            CLEAR: begin
                clr_we     = 1'b1;
                clr_active = 1'b1;
                if (idx == LAST_IDX) begin
                    state_nxt = DONE;
                    idx_nxt   = '0;
                end else begin
                    idx_nxt = idx + 1'b1;
                end
            end
            DONE: begin
                clr_active = 1'b1;
                clr_done   = 1'b1;
                state_nxt  = IDLE;
            end
            default: begin
                state_nxt = IDLE;
                idx_nxt   = '0;
            end
        endcase
    end

    assign clr_idx = idx;

endmodule

// File: rtl/regfile_scoreboard.sv
// Two-read/one-write register file with write bypass, pending-write scoreboard
// and a sequenced bulk clear.
module regfile_scoreboard
    import regfile_pkg::*;
#(
    parameter int DATA_W   = DATA_W_DEF,
    parameter int NUM_REGS = NUM_REGS_DEF,
    parameter int ZERO_REG = 1,
    localparam int ADDR_W  = $clog2(NUM_REGS)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [ADDR_W-1:0] rd_addr1,
    input  logic [ADDR_W-1:0] rd_addr2,
    output logic [DATA_W-1:0] rd_data1,
    output logic [DATA_W-1:0] rd_data2,
    output logic              rd_busy1,
    output logic              rd_busy2,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              busy_set,
    input  logic [ADDR_W-1:0] busy_addr,
    input  logic              clr_start,
    output logic              clr_active,
    output logic              clr_done
);

    logic [DATA_W-1:0]   mem [NUM_REGS];
    logic [NUM_REGS-1:0] busy;

    logic              clr_we;
    logic [ADDR_W-1:0] clr_idx;

    logic zero_wr, zero_set, zero_rd1, zero_rd2;
    logic wr_acc, set_acc, hit1, hit2;

    rf_clear_seq #(
        .NUM_REGS (NUM_REGS),
        .ADDR_W   (ADDR_W)
    ) u_clear_seq (
        .clk        (clk),
        .rst_n      (rst_n),
        .clr_start  (clr_start),
        .clr_we     (clr_we),
        .clr_idx    (clr_idx),
        .clr_active (clr_active),
        .clr_done   (clr_done)
    );

    assign zero_wr  = (ZERO_REG != 0) && (wr_addr == '0);
    assign zero_set = (ZERO_REG != 0) && (busy_addr == '0);
    assign zero_rd1 = (ZERO_REG != 0) && (rd_addr1 == '0);
    assign zero_rd2 = (ZERO_REG != 0) && (rd_addr2 == '0);

    assign wr_acc  = wr_en && !clr_active && !zero_wr;
    assign set_acc = busy_set && !clr_active && !zero_set;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                mem[i] <= '0;
            end
        end else if (clr_we) begin
            mem[clr_idx] <= '0;
        end else if (wr_acc) begin
            mem[wr_addr] <= wr_data;
        end
    end

    // The set is issued after the clear so it wins when both hit one address.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy <= '0;
        end else if (clr_done) begin
            busy <= '0;
        end else begin
            if (wr_acc) begin
                busy[wr_addr] <= 1'b0;
            end
            if (set_acc) begin
                busy[busy_addr] <= 1'b1;
            end
        end
    end

    assign hit1 = wr_acc && (wr_addr == rd_addr1);
    assign hit2 = wr_acc && (wr_addr == rd_addr2);

    assign rd_data1 = zero_rd1 ? '0 : (hit1 ? wr_data : mem[rd_addr1]);
    assign rd_data2 = zero_rd2 ? '0 : (hit2 ? wr_data : mem[rd_addr2]);

    assign rd_busy1 = !zero_rd1 && busy[rd_addr1] && !hit1;
    assign rd_busy2 = !zero_rd2 && busy[rd_addr2] && !hit2;

endmodule
